dma_control_mc: RTL and testbench
=================================

DMA_CONTROL_MC -- requirements
Module: dma_control_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent DMA channels (1..16).
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 SHALL have parameter TOP_LEN_WIDTH, default 32, meaning descriptor length width in beats.
REQ-004 SHALL have parameter CONFIG_LEN_WIDTH, default 9, meaning burst length field width.
REQ-005 SHALL have parameter MAX_BURST, default 64, meaning max beats per burst; must not exceed 2**CONFIG_LEN_WIDTH-1.
REQ-006 SHALL have parameter BEAT_BYTES, default 4, meaning bytes per beat; power of two.
REQ-007 SHALL have port clk  input  1  meaning the single clock; all logic on posedge.
REQ-008 SHALL have port rst  input  1  meaning reset, asynchronous, active-high.
REQ-009 SHALL have port ch_desc_valid  input  NUM_CH  meaning per-channel descriptor load strobe.
REQ-010 SHALL have port ch_desc_addr  input  NUM_CH x AXI_ADDR_WIDTH  meaning start byte address.
REQ-011 SHALL have port ch_desc_len  input  NUM_CH x TOP_LEN_WIDTH  meaning total beats.
REQ-012 SHALL have port ch_start  input  NUM_CH  meaning per-channel start strobe.
REQ-013 SHALL have port ch_abort  input  NUM_CH  meaning per-channel abort strobe.
REQ-014 SHALL have port ch_cfg_empty  input  NUM_CH  meaning downstream has no outstanding bursts for that channel.
REQ-015 SHALL have port ch_done  output  NUM_CH  meaning channel idle.
REQ-016 SHALL have port config_valid  output  1; config_ready  input  1  meaning shared burst-request handshake.
REQ-017 SHALL have port config_ch  output  $clog2(NUM_CH) (min 1)  meaning issuing channel.
REQ-018 SHALL have port config_len  output  CONFIG_LEN_WIDTH; config_addr  output  AXI_ADDR_WIDTH  meaning burst beats and byte address.

Function
REQ-019 SHALL give each channel states IDLE, RUN, DRAIN; ch_done=1 only in IDLE.
REQ-020 SHALL in IDLE load addr (low log2(BEAT_BYTES) bits cleared) and len on ch_desc_valid; ch_start same cycle is ignored; otherwise ch_start moves to RUN next cycle.
REQ-021 SHALL move RUN to DRAIN when remaining len==0, and DRAIN to IDLE when ch_cfg_empty==1.
REQ-022 SHALL compute burst = min(remaining len, MAX_BURST), subject to REQ-030.
REQ-023 SHALL on accepted burst (valid&&ready) add burst*BEAT_BYTES to address (wrap modulo 2**AXI_ADDR_WIDTH) and subtract burst from len.
REQ-024 SHALL arbitrate RUN channels with len!=0 round-robin; priority pointer moves to granted+1 (mod NUM_CH) only on acceptance.
REQ-025 SHALL drive config_* combinationally from granted channel state; all zero when config_valid==0.
REQ-026 SHALL hold grant, config_ch, config_len, config_addr stable while config_valid&&!config_ready.
REQ-027 SHALL on ch_abort in RUN zero len and enter DRAIN next cycle; if that channel holds an unaccepted grant, abort is deferred until acceptance; ch_abort in IDLE/DRAIN ignored.
REQ-028 SHALL ignore ch_desc_valid and ch_start outside IDLE.
REQ-029 SHALL issue at most one burst per cycle; zero-length start goes IDLE->RUN->DRAIN with no burst.

Reset
REQ-030-R SHALL on rst asynchronously set all channels IDLE, ch_done all 1, addr/len 0, pointer 0, config_valid 0; mid-transfer reset discards outstanding work.

Configuration
REQ-030 SHALL, with DMA_CTRL_4K_SPLIT_EN defined, further limit burst to (4096 - addr[11:0])/BEAT_BYTES so no burst crosses a 4 KiB boundary; without it, no boundary limit.

Structure
REQ-031 SHALL place channel-state enum, descriptor struct typedef and default constants in package dma_pkg.
REQ-032 SHALL implement arbitration in sub-module dma_rr_arb (NUM_CH requests, accept input, one-hot grant, pointer).

Verification
REQ-033 SHALL cover: ch0 addr 0x1000 len 150, ready=1 -> bursts (0x1000,64),(0x1100,64),(0x1200,22), then done after cfg_empty.
REQ-034 SHALL cover: ch0..ch3 all RUN len 128, ready=1 -> config_ch sequence 0,1,2,3,0,1,2,3.
REQ-035 SHALL cover: ready=0 for 5 cycles with ch1 granted, ch2 raising request -> outputs stable, ch1 accepted first.
REQ-036 SHALL cover: ch0 abort during unaccepted burst at len 200 -> burst 64 completes, no further bursts, DRAIN then IDLE.
REQ-037 SHALL cover: with DMA_CTRL_4K_SPLIT_EN, addr 0x0FF0 len 64 -> (0x0FF0,4),(0x1000,60); without it -> (0x0FF0,64).
REQ-038 SHALL cover: rst asserted mid-burst -> config_valid 0 and ch_done all 1 same cycle asynchronously.

Source files
------------

// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared types and default constants for the multi-channel DMA controller.
//   ch_state_e  : per-channel state (IDLE / RUN / DRAIN)
//   dma_desc_t  : descriptor (start byte address + length in beats) at the
//                 default widths
//   idx_width() : index width for N items, never smaller than 1
// -----------------------------------------------------------------------------
package dma_pkg;

    localparam int DMA_DEF_NUM_CH     = 4;
    localparam int DMA_DEF_ADDR_W     = 32;
    localparam int DMA_DEF_LEN_W      = 32;
    localparam int DMA_DEF_CFG_LEN_W  = 9;
    localparam int DMA_DEF_MAX_BURST  = 64;
    localparam int DMA_DEF_BEAT_BYTES = 4;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_RUN   = 2'd1,
        CH_DRAIN = 2'd2
    } ch_state_e;

    typedef struct packed {
        logic [DMA_DEF_ADDR_W-1:0] addr;
        logic [DMA_DEF_LEN_W-1:0]  len;
    } dma_desc_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// -----------------------------------------------------------------------------
// dma_rr_arb
// Round-robin arbiter for the shared burst-request port.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req_i        : one request bit per channel
//   accept_i     : the granted request was accepted this cycle
//   grant_o      : one-hot grant (all zero when no request)
//   grant_idx_o  : binary index of the granted channel
//   ptr_o        : current priority pointer
// The pointer moves to granted+1 only on acceptance. While a grant is
// pending (request present, not accepted) the winner is locked so that a
// newly raised higher-priority request cannot steal an offered burst.
// -----------------------------------------------------------------------------
module dma_rr_arb
    import dma_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          accept_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic [IW-1:0] ptr_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          lock_q, lock_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          any_req;

    assign any_req = |req_i;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        int c;
        c          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr_q) + i;
            if (c >= N) c = c - N;
            if (!pick_found && req_i[c]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(c);
            end
        end
    end

    assign grant_idx_o = lock_q ? lock_idx_q : pick_idx;
    assign grant_o     = any_req ? (N'(1) << grant_idx_o) : '0;
    assign ptr_o       = ptr_q;

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = 1'b0;
        lock_idx_d = lock_idx_q;
        if (any_req && accept_i) begin
            ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
        end else if (any_req) begin
            lock_d     = 1'b1;
            lock_idx_d = grant_idx_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/dma_control_mc.sv
// -----------------------------------------------------------------------------
// dma_control_mc
// Multi-channel DMA control: each channel walks a descriptor (byte address,
// length in beats) and issues bursts of at most MAX_BURST beats on one shared
// request port, arbitrated round-robin.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   ch_desc_valid/addr/len   : per-channel descriptor load (IDLE only)
//   ch_start, ch_abort       : per-channel start / abort strobes
//   ch_cfg_empty             : downstream holds no bursts for the channel
//   ch_done                  : channel is IDLE
//   config_valid/ready       : shared burst request handshake
//   config_ch/len/addr       : granted channel, burst beats, byte address
//   dbg_ch_state, dbg_rr_ptr : channel states and arbiter pointer (debug)
// Handshake: a burst transfers on a cycle where config_valid && config_ready.
// Once config_valid is high, config_* stays unchanged until that happens;
// config_* is zero whenever config_valid is low.
// Build option: define DMA_CTRL_4K_SPLIT_EN to keep every burst within one
// 4 KiB page.
// -----------------------------------------------------------------------------
module dma_control_mc
    import dma_pkg::*;
#(
    parameter  int NUM_CH           = DMA_DEF_NUM_CH,
    parameter  int AXI_ADDR_WIDTH   = DMA_DEF_ADDR_W,
    parameter  int TOP_LEN_WIDTH    = DMA_DEF_LEN_W,
    parameter  int CONFIG_LEN_WIDTH = DMA_DEF_CFG_LEN_W,
    parameter  int MAX_BURST        = DMA_DEF_MAX_BURST,
    parameter  int BEAT_BYTES       = DMA_DEF_BEAT_BYTES,
    localparam int CH_W             = idx_width(NUM_CH)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_CH-1:0]                      ch_desc_valid,
    input  logic [NUM_CH-1:0][AXI_ADDR_WIDTH-1:0]  ch_desc_addr,
    input  logic [NUM_CH-1:0][TOP_LEN_WIDTH-1:0]   ch_desc_len,
    input  logic [NUM_CH-1:0]                      ch_start,
    input  logic [NUM_CH-1:0]                      ch_abort,
    input  logic [NUM_CH-1:0]                      ch_cfg_empty,
    output logic [NUM_CH-1:0]                      ch_done,
    output logic                                   config_valid,
    input  logic                                   config_ready,
    output logic [CH_W-1:0]                        config_ch,
    output logic [CONFIG_LEN_WIDTH-1:0]            config_len,
    output logic [AXI_ADDR_WIDTH-1:0]              config_addr,
    output ch_state_e [NUM_CH-1:0]                 dbg_ch_state,
    output logic [CH_W-1:0]                        dbg_rr_ptr
);

    localparam int BB_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LOW_MASK = AXI_ADDR_WIDTH'(BEAT_BYTES - 1);

    ch_state_e [NUM_CH-1:0]    state_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q [NUM_CH];
    logic [TOP_LEN_WIDTH-1:0]  len_q  [NUM_CH];
    logic [NUM_CH-1:0]         abort_pend_q;
    logic [NUM_CH-1:0]         done_q;

    logic [NUM_CH-1:0]         req;
    logic [NUM_CH-1:0]         grant;
    logic [CH_W-1:0]           g_idx;
    logic [AXI_ADDR_WIDTH-1:0] g_addr;
    logic [TOP_LEN_WIDTH-1:0]  g_len;
    logic [TOP_LEN_WIDTH-1:0]  burst_w;
    logic [AXI_ADDR_WIDTH-1:0] addr_inc;
    logic                      accept;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req[i] = (state_q[i] == CH_RUN) && (len_q[i] != '0);
        end
    end

    dma_rr_arb #(.N(NUM_CH)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .accept_i    (accept),
        .grant_o     (grant),
        .grant_idx_o (g_idx),
        .ptr_o       (dbg_rr_ptr)
    );

    assign g_addr = addr_q[g_idx];
    assign g_len  = len_q[g_idx];

`ifdef DMA_CTRL_4K_SPLIT_EN
    logic [12:0] page_room;
    logic [12:0] page_beats;
`endif

    // Burst size: remaining length capped at MAX_BURST, optionally also capped
    // at the beats left before the next 4 KiB page.
    always_comb begin
        burst_w = g_len;
        if (g_len > TOP_LEN_WIDTH'(MAX_BURST)) begin
            burst_w = TOP_LEN_WIDTH'(MAX_BURST);
        end
`ifdef DMA_CTRL_4K_SPLIT_EN
        page_room  = 13'd4096 - {1'b0, g_addr[11:0]};
        page_beats = page_room >> BB_SHIFT;
        if (TOP_LEN_WIDTH'(page_beats) < burst_w) begin
            burst_w = TOP_LEN_WIDTH'(page_beats);
        end
`endif
    end

    assign addr_inc     = AXI_ADDR_WIDTH'(burst_w) << BB_SHIFT;
    assign config_valid = |req;
    assign accept       = config_valid && config_ready;
    assign config_ch    = config_valid ? g_idx : '0;
    assign config_len   = config_valid ? CONFIG_LEN_WIDTH'(burst_w) : '0;
    assign config_addr  = config_valid ? g_addr : '0;
    assign ch_done      = done_q;
    assign dbg_ch_state = state_q;

    // Per-channel FSMs. ch_done is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= CH_IDLE;
                addr_q[i]  <= '0;
                len_q[i]   <= '0;
            end
            abort_pend_q <= '0;
            done_q       <= '1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                case (state_q[i])
                    CH_IDLE: begin
                        // A load takes precedence over a same-cycle start.
                        if (ch_desc_valid[i]) begin
                            addr_q[i] <= ch_desc_addr[i] & ~ADDR_LOW_MASK;
                            len_q[i]  <= ch_desc_len[i];
                        end else if (ch_start[i]) begin
                            state_q[i] <= CH_RUN;
                            done_q[i]  <= 1'b0;
                        end
                    end
                    CH_RUN: begin
                        if (accept && grant[i]) begin
                            addr_q[i] <= addr_q[i] + addr_inc;
                            if (ch_abort[i] || abort_pend_q[i]) begin
                                len_q[i]        <= '0;
                                abort_pend_q[i] <= 1'b0;
                                state_q[i]      <= CH_DRAIN;
                            end else begin
                                len_q[i] <= len_q[i] - burst_w;
                            end
                        end else if (len_q[i] == '0) begin
                            state_q[i] <= CH_DRAIN;
                        end else if (ch_abort[i]) begin
                            // An offered burst must complete; remember the abort.
                            if (grant[i]) begin
                                abort_pend_q[i] <= 1'b1;
                            end else begin
                                len_q[i]   <= '0;
                                state_q[i] <= CH_DRAIN;
                            end
                        end
                    end
                    CH_DRAIN: begin
                        abort_pend_q[i] <= 1'b0;
                        if (ch_cfg_empty[i]) begin
                            state_q[i] <= CH_IDLE;
                            done_q[i]  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q[i] <= CH_IDLE;
                        done_q[i]  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_control_mc.sv
// -----------------------------------------------------------------------------
// tb_dma_control_mc
// Self-checking bench for dma_control_mc. Expected bursts per channel are
// derived from each descriptor by splitting it arithmetically, pushed into
// per-channel queues at issue time, and popped by a monitor at every
// accepted burst. Expected grant order, where it matters, sits in ord_q.
// -----------------------------------------------------------------------------
module tb_dma_control_mc;
    import dma_pkg::*;

    localparam int NUM_CH = 4;
    localparam int AW     = 32;
    localparam int LW     = 32;
    localparam int CLW    = 9;
    localparam int MAXB   = 64;
    localparam int BB     = 4;
    localparam int BUDGET = 3000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]          ch_desc_valid = '0;
    logic [NUM_CH-1:0][AW-1:0]  ch_desc_addr  = '0;
    logic [NUM_CH-1:0][LW-1:0]  ch_desc_len   = '0;
    logic [NUM_CH-1:0]          ch_start      = '0;
    logic [NUM_CH-1:0]          ch_abort      = '0;
    logic [NUM_CH-1:0]          ch_cfg_empty  = '1;
    logic [NUM_CH-1:0]          ch_done;
    logic                       config_valid;
    logic                       config_ready = 1'b0;
    logic [1:0]                 config_ch;
    logic [CLW-1:0]             config_len;
    logic [AW-1:0]              config_addr;
    ch_state_e [NUM_CH-1:0]     dbg_ch_state;
    logic [1:0]                 dbg_rr_ptr;

    dma_control_mc dut (
        .clk           (clk),
        .rst           (rst),
        .ch_desc_valid (ch_desc_valid),
        .ch_desc_addr  (ch_desc_addr),
        .ch_desc_len   (ch_desc_len),
        .ch_start      (ch_start),
        .ch_abort      (ch_abort),
        .ch_cfg_empty  (ch_cfg_empty),
        .ch_done       (ch_done),
        .config_valid  (config_valid),
        .config_ready  (config_ready),
        .config_ch     (config_ch),
        .config_len    (config_len),
        .config_addr   (config_addr),
        .dbg_ch_state  (dbg_ch_state),
        .dbg_rr_ptr    (dbg_rr_ptr)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [AW+CLW-1:0] exp_q [NUM_CH][$];  // {addr, len}
    int ord_q[$];
    int ready_mode = 1;  // 0: low, 1: high, 2: random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready is driven from one place; tests only pick the mode.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       config_ready = 1'b0;
            1:       config_ready = 1'b1;
            default: config_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- reference model ----------------
    task automatic push_model(input int ch, input logic [AW-1:0] addr, input int len);
        logic [AW-1:0] a;
        int rem;
        int b;
        a   = addr & ~32'h3;
        rem = len;
        while (rem > 0) begin
            b = (rem < MAXB) ? rem : MAXB;
`ifdef DMA_CTRL_4K_SPLIT_EN
            begin
                int room;
                room = (4096 - int'(a % 4096)) / BB;
                if (room < b) b = room;
            end
`endif
            exp_q[ch].push_back({a, CLW'(b)});
            a   = a + AW'(b * BB);
            rem = rem - b;
        end
    endtask

    // ---------------- monitor ----------------
    logic          prev_stall = 1'b0;
    logic [1:0]    prev_ch;
    logic [AW+CLW-1:0] prev_cfg;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", 64'({config_valid, config_ch, config_addr, config_len}),
                      64'({1'b1, prev_ch, prev_cfg}));
            end
            if (config_valid && config_ready) begin
                if (ord_q.size() > 0) begin
                    check("grant_order", 64'(config_ch), 64'(ord_q.pop_front()));
                end
                if (exp_q[config_ch].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL burst_unexpected: ch %0d got addr 0x%0h len %0d, expected no burst",
                             config_ch, config_addr, config_len);
                end else begin
                    check("burst", 64'({config_addr, config_len}), 64'(exp_q[config_ch].pop_front()));
                end
            end else if (!config_valid) begin
                check("idle_outputs_zero", 64'({config_ch, config_len, config_addr}), 64'(0));
            end
            prev_stall = config_valid && !config_ready;
            prev_ch    = config_ch;
            prev_cfg   = {config_addr, config_len};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_desc(input int ch, input logic [AW-1:0] addr, input int len, input bit push);
        ch_desc_addr[ch] = addr;
        ch_desc_len[ch]  = LW'(len);
        if (push) push_model(ch, addr, len);
    endtask

    task automatic fire(input logic [NUM_CH-1:0] mask);
        @(posedge clk); #1 ch_desc_valid = mask;
        @(posedge clk); #1 ch_desc_valid = '0; ch_start = mask;
        @(posedge clk); #1 ch_start = '0;
    endtask

    function automatic bit queues_empty(input logic [NUM_CH-1:0] mask);
        bit e;
        e = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i] && exp_q[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_done(input logic [NUM_CH-1:0] mask);
        int k;
        k = 0;
        while ((((ch_done & mask) != mask) || !queues_empty(mask)) && k < BUDGET) begin
            @(posedge clk);
            k++;
        end
        n_cmp++;
        if (k >= BUDGET) begin
            n_fail++;
            $display("FAIL wait_done: ch_done=%b required mask %b within %0d cycles", ch_done, mask, BUDGET);
        end
    endtask

    task automatic wait_drained(input int ch);
        int k;
        k = 0;
        while (exp_q[ch].size() != 0 && k < BUDGET) begin
            @(posedge clk);
            k++;
        end
        n_cmp++;
        if (k >= BUDGET) begin
            n_fail++;
            $display("FAIL wait_drained: ch %0d still expects %0d bursts, required 0", ch, exp_q[ch].size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ch_desc_valid = '0;
        ch_start      = '0;
        ch_abort      = '0;
        ch_cfg_empty  = '1;
        for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
        ord_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_done", 64'(ch_done), 64'(4'hF));
        check("reset_valid", 64'(config_valid), 64'(0));
        do_reset();
        check("reset_ptr", 64'(dbg_rr_ptr), 64'(0));

        // Single channel split into 64/64/22; done only after cfg_empty.
        ready_mode   = 1;
        ch_cfg_empty = 4'b1110;
        set_desc(0, 32'h1000, 150, 0);
        exp_q[0].push_back({32'h1000, 9'd64});
        exp_q[0].push_back({32'h1100, 9'd64});
        exp_q[0].push_back({32'h1200, 9'd22});
        fire(4'b0001);
        wait_drained(0);
        repeat (3) @(posedge clk);
        #1;
        check("t1_state_drain", 64'(dbg_ch_state[0]), 64'(CH_DRAIN));
        check("t1_not_done", 64'(ch_done[0]), 64'(0));
        ch_cfg_empty = 4'hF;
        @(posedge clk); #1;
        check("t1_done", 64'(ch_done[0]), 64'(1));

        // Four channels started together: strict rotation 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < NUM_CH; i++) set_desc(i, AW'(32'h10100 * (i + 1)), 128, 1);
        for (int r = 0; r < 2; r++) for (int i = 0; i < NUM_CH; i++) ord_q.push_back(i);
        fire(4'hF);
        wait_done(4'hF);

        // Stall with ch1 offered while ch0 (higher priority) and ch2 join.
        ready_mode = 0;
        set_desc(1, 32'h3000, 64, 1);
        fire(4'b0010);
        set_desc(0, 32'h4000, 64, 1);
        set_desc(2, 32'h5000, 64, 1);
        fire(4'b0101);
        repeat (3) @(posedge clk);
        #1;
        check("t3_grant_held", 64'({config_valid, config_ch}), 64'({1'b1, 2'd1}));
        ord_q.push_back(1);
        ord_q.push_back(2);
        ord_q.push_back(0);
        ready_mode = 1;
        wait_done(4'b0111);

        // Abort while the first burst is offered but not accepted.
        ready_mode   = 0;
        ch_cfg_empty = 4'b1110;
        set_desc(0, 32'h2000, 200, 0);
        exp_q[0].push_back({32'h2000, 9'd64});
        fire(4'b0001);
        ch_abort = 4'b0001;
        @(posedge clk); #1 ch_abort = '0;
        repeat (2) @(posedge clk);
        #1 ready_mode = 1;
        wait_drained(0);
        repeat (5) @(posedge clk);
        #1;
        check("t4_state_drain", 64'(dbg_ch_state[0]), 64'(CH_DRAIN));
        check("t4_not_done", 64'(ch_done[0]), 64'(0));
        ch_cfg_empty = 4'hF;
        @(posedge clk); #1;
        check("t4_done", 64'(ch_done[0]), 64'(1));

        // Page-boundary descriptor and a zero-length start.
        set_desc(0, 32'h0FF0, 64, 0);
`ifdef DMA_CTRL_4K_SPLIT_EN
        exp_q[0].push_back({32'h0FF0, 9'd4});
        exp_q[0].push_back({32'h1000, 9'd60});
`else
        exp_q[0].push_back({32'h0FF0, 9'd64});
`endif
        set_desc(1, 32'h6000, 0, 0);
        fire(4'b0011);
        wait_done(4'b0011);

        // Randomized descriptors with random ready; loads/starts while
        // running must be ignored.
        ready_mode = 2;
        for (int it = 0; it < 25; it++) begin
            logic [NUM_CH-1:0] mask;
            mask = NUM_CH'($urandom_range(1, 15));
            for (int i = 0; i < NUM_CH; i++) begin
                if (mask[i]) begin
                    logic [AW-1:0] a;
                    logic [AW-1:0] r;
                    r = $urandom;
                    case ($urandom_range(0, 2))
                        0:       a = r;
                        1:       a = (r & 32'hFFFF_F000) | 32'h0000_0F00 | (r & 32'h0000_00FF);
                        default: a = 32'hFFFF_FF00 | (r & 32'h0000_00FF);
                    endcase
                    set_desc(i, a, $urandom_range(0, 300), 1);
                end
            end
            fire(mask);
            ch_desc_valid = mask;
            ch_start      = mask;
            for (int i = 0; i < NUM_CH; i++) ch_desc_addr[i] = $urandom;
            @(posedge clk); #1;
            ch_desc_valid = '0;
            ch_start      = '0;
            wait_done(mask);
        end

        // Asynchronous reset in the middle of an offered burst.
        ready_mode = 0;
        set_desc(2, 32'h7000, 100, 0);
        fire(4'b0100);
        repeat (2) @(posedge clk);
        #1;
        check("t7_valid_before_rst", 64'(config_valid), 64'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_valid", 64'(config_valid), 64'(0));
        check("t7_rst_done", 64'(ch_done), 64'(4'hF));
        do_reset();
        ready_mode = 1;
        repeat (10) @(posedge clk);
        #1;
        check("t7_after_done", 64'(ch_done), 64'(4'hF));
        check("t7_after_valid", 64'(config_valid), 64'(0));

        // ---------------- final report ----------------
        for (int i = 0; i < NUM_CH; i++) check("queue_empty", 64'(exp_q[i].size()), 64'(0));
        check("order_queue_empty", 64'(ord_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
